// File: rtl/otter_sseg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   NUM_DIGITS   number of multiplexed digits on the board display
//   SEG_DASH     cathode pattern for "-" (DP off)
//   SEG_BLANK    cathode pattern with every segment dark (DP off)
//   seg_encode   hex nibble -> active-low {g,f,e,d,c,b,a}
//   cnv_state_e  states of the sequential binary-to-BCD converter
package otter_sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } cnv_state_e;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Load port of the seven-segment driver (valid/ready).
//   DATA   16-bit value to display
//   DP     per-digit decimal points, active-high
//   VALID  DATA/DP offered this cycle
//   READY  load accepted on cycles where VALID & READY
// master: the MMIO writer; slave: the display driver.
interface sseg_scan_driver_if;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic        VALID;
  logic        READY;

  modport master (output DATA, output DP, output VALID, input READY);
  modport slave  (input DATA, input DP, input VALID, output READY);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter (16 cycles per value).
//   clk_i, rst_ni           clock, synchronous active-low reset
//   in_valid/in_data        binary value offered; taken when in_ready is high
//   in_ready                high only while idle
//   out_valid               one-cycle pulse with the finished result
//   out_bcd                 four low decimal digits
//   out_ovf                 value was above 9999 (a fifth digit was needed)
// Used by sseg_scan_driver only when SSEG_BCD_EN is defined.
module bin2bcd_seq
  import otter_sseg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic        out_ovf
);

  cnv_state_e  state_q, state_d;
  logic [31:0] sr_q, sr_d;      // {bcd, bin}
  logic [3:0]  iter_q, iter_d;
  logic        ovf_q, ovf_d;
  logic [31:0] adj;

  always_comb begin
    // Add-3 correction on every BCD field before the shift.
    adj = sr_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sr_q[16 + 4 * i +: 4] >= 4'd5) begin
        adj[16 + 4 * i +: 4] = sr_q[16 + 4 * i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    iter_d    = iter_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d    = {16'h0000, in_data};
          iter_d  = 4'd0;
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d   = {adj[30:0], 1'b0};
        // A bit leaving the 4-digit field means a nonzero fifth digit; it never returns to 0.
        ovf_d  = ovf_q | adj[31];
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      sr_q    <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_bcd = sr_q[31:16];
  assign out_ovf = ovf_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
//   CLK       system clock
//   RST_N     synchronous active-low reset
//   ld        load port (sseg_scan_driver_if.slave): DATA, DP, VALID, READY
//   CATHODES  active-low, [7]=DP, [6:0]=g..a, registered
//   ANODES    active-low digit enables, [0]=rightmost, registered
// Parameters: CLK_DIV cycles per lit digit (>= 2); BLANK_LZ blanks leading zero digits.
// Macro SSEG_BCD_EN: when defined, loads go through bin2bcd_seq and the display is decimal;
// when undefined, the display is hex and READY is constant 1.
module sseg_scan_driver
  import otter_sseg_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                CLK,
  input  logic                RST_N,
  sseg_scan_driver_if.slave   ld,
  output logic [7:0]          CATHODES,
  output logic [3:0]          ANODES
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [15:0]     disp_q, disp_d;
  logic [3:0]      dp_q, dp_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      anodes_q, anodes_d;
  logic [7:0]      cathodes_q, cathodes_d;

  // Refresh counter and digit index run freely; loads never disturb them.
  always_comb begin
    cnt_d   = cnt_q + CntW'(1);
    digit_d = digit_q;
    if (cnt_q == CntMax) begin
      cnt_d   = '0;
      digit_d = digit_q + 2'd1;
    end
  end

`ifdef SSEG_BCD_EN
  logic        bcd_ready;
  logic        bcd_out_valid;
  logic [15:0] bcd_out;
  logic        bcd_ovf;
  logic [3:0]  pend_dp_q, pend_dp_d;

  bin2bcd_seq u_bin2bcd (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .in_valid  (ld.VALID),
    .in_data   (ld.DATA),
    .in_ready  (bcd_ready),
    .out_valid (bcd_out_valid),
    .out_bcd   (bcd_out),
    .out_ovf   (bcd_ovf)
  );

  assign ld.READY = bcd_ready;

  // DP is held aside so it changes together with the converted digits.
  always_comb begin
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    dp_d      = dp_q;
    ovf_d     = ovf_q;
    if (ld.VALID && bcd_ready) begin
      pend_dp_d = ld.DP;
    end
    if (bcd_out_valid) begin
      disp_d = bcd_out;
      dp_d   = pend_dp_q;
      ovf_d  = bcd_ovf;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_dp_q <= '0;
    end else begin
      pend_dp_q <= pend_dp_d;
    end
  end
`else
  assign ld.READY = 1'b1;

  always_comb begin
    disp_d = disp_q;
    dp_d   = dp_q;
    ovf_d  = 1'b0;
    if (ld.VALID) begin
      disp_d = ld.DATA;
      dp_d   = ld.DP;
    end
  end
`endif

  // Digit rendering from the current index and display register.
  logic [3:0] nib;
  logic [1:0] msd;
  logic       blank;
  logic [6:0] seg7;

  always_comb begin
    nib = 4'(disp_q >> {digit_q, 2'b00});
    if (disp_q[15:12] != 4'h0) begin
      msd = 2'd3;
    end else if (disp_q[11:8] != 4'h0) begin
      msd = 2'd2;
    end else if (disp_q[7:4] != 4'h0) begin
      msd = 2'd1;
    end else begin
      msd = 2'd0;
    end
    blank = BLANK_LZ && (digit_q > msd);
    if (ovf_q) begin
      seg7 = SEG_DASH[6:0];
    end else if (blank) begin
      seg7 = SEG_BLANK[6:0];
    end else begin
      seg7 = seg_encode(nib);
    end
    cathodes_d = {~dp_q[digit_q], seg7};
    anodes_d   = ~(4'b0001 << digit_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      digit_q    <= '0;
      disp_q     <= '0;
      dp_q       <= '0;
      ovf_q      <= 1'b0;
      anodes_q   <= 4'hF;
      cathodes_q <= 8'hFF;
    end else begin
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      disp_q     <= disp_d;
      dp_q       <= dp_d;
      ovf_q      <= ovf_d;
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
    end
  end

  assign ANODES   = anodes_q;
  assign CATHODES = cathodes_q;

endmodule
